adc_ram_frame_ctrl: RTL and testbench

//  Sequences one adc_ram instance as a single-frame capture buffer.

---
 rtl/adc_ram_frame_ctrl_pkg.sv | 24 ++
 rtl/adc_ram_frame_ofifo.sv | 64 ++++++
 rtl/adc_ram_frame_ctrl.sv | 171 +++++++++++++++++
 tb/tb_adc_ram_frame_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_ram_frame_ctrl_pkg.sv
// Shared definitions for the adc_ram single-frame capture controller.
// Holds the FSM state encoding, default geometry and a counter-width helper.
package adc_ram_frame_ctrl_pkg;

  // Default geometry: one frame fills the whole 8192 x 160 adc_ram.
  localparam int unsigned DEF_DWIDTH      = 160;
  localparam int unsigned DEF_AWIDTH      = 13;
  localparam int unsigned DEF_FRAME_WORDS = 8192;

  // Output FIFO depth; covers one cycle of read latency plus one stalled word.
  localparam int unsigned OFIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } frame_state_e;

  // Counters must reach n itself (they park at FRAME_WORDS), so size for n+1 values.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/adc_ram_frame_ofifo.sv
// 2-entry synchronous FIFO holding drain words (data plus last flag).
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   i_push       : write i_push_data this cycle
//   i_push_data  : WIDTH-bit entry
//   i_pop        : consume head this cycle (ignored when empty)
//   o_head       : current head entry
//   o_count      : occupancy 0..2
module adc_ram_frame_ofifo
  import adc_ram_frame_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_DWIDTH + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [1:0]       o_count
);

  localparam logic [1:0] FULL_CNT = 2'(OFIFO_DEPTH);

  logic [WIDTH-1:0] r_mem [OFIFO_DEPTH];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop && (r_count != 2'd0);
  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign w_push = i_push && ((r_count != FULL_CNT) || w_pop);

  // Pointers, occupancy and storage; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
      for (int i = 0; i < int'(OFIFO_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_push_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/adc_ram_frame_ctrl.sv
// Sequences one adc_ram as a single-frame capture buffer: fills FRAME_WORDS
// words from the ADC packer, then drains them in address order on a
// valid/ready stream toward the matrix engine. Owns both RAM ports.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   start                  : arm one frame capture (IDLE only)
//   in_valid, in_data      : write-side word stream, no backpressure
//   ram_wen/waddr/wdat     : adc_ram write port (driven in FILL only)
//   ram_raddr, ram_rdat    : adc_ram read port, one cycle read latency
//   out_valid/ready/data   : drain stream
//   out_last               : marks final word of the frame
//   busy                   : FILL or DRAIN
//   done                   : one-cycle pulse after the last word is accepted
//   overflow               : sticky flag for words arriving outside FILL
module adc_ram_frame_ctrl
  import adc_ram_frame_ctrl_pkg::*;
#(
  parameter int unsigned DWIDTH      = DEF_DWIDTH,
  parameter int unsigned AWIDTH      = DEF_AWIDTH,
  parameter int unsigned FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              ram_wen,
  output logic [AWIDTH-1:0] ram_waddr,
  output logic [DWIDTH-1:0] ram_wdat,
  output logic [AWIDTH-1:0] ram_raddr,
  input  logic [DWIDTH-1:0] ram_rdat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int unsigned CW       = cnt_width(FRAME_WORDS);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_WORDS - 1);
  localparam logic [CW-1:0] END_CNT  = CW'(FRAME_WORDS);

  frame_state_e     r_state;
  frame_state_e     w_state_nxt;
  logic [CW-1:0]    r_wcnt;
  logic [CW-1:0]    r_rcnt;
  logic             r_inflight;
  logic             r_inflight_last;
  logic             r_overflow;
  logic             r_busy;
  logic             r_done;

  logic             w_start_acc;
  logic             w_wr_acc;
  logic             w_issue;
  logic             w_pop;
  logic             w_last_pop;
  logic [2:0]       w_occ;
  logic [1:0]       w_fcnt;
  logic [DWIDTH:0]  w_head;

  // Event decode shared by FSM and datapath.
  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign w_wr_acc    = (r_state == ST_FILL) && in_valid && (r_wcnt < END_CNT);
  assign w_pop       = out_valid && out_ready;
  assign w_last_pop  = w_pop && w_head[DWIDTH];

  // Words already committed to the FIFO after this cycle's pop; stay below depth.
  assign w_occ   = 3'(w_fcnt) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue = (r_state == ST_DRAIN) && (r_rcnt < END_CNT) &&
                   (w_occ < 3'(OFIFO_DEPTH));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and combinational RAM write port.
  always_comb begin
    w_state_nxt = r_state;
    ram_wen     = 1'b0;
    ram_waddr   = AWIDTH'(r_wcnt);
    ram_wdat    = in_data;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        ram_wen = w_wr_acc;
        if (w_wr_acc && (r_wcnt == LAST_IDX)) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_last_pop) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Counters, read pipeline tracking and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wcnt          <= '0;
      r_rcnt          <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_overflow      <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_busy          <= (w_state_nxt != ST_IDLE);
      r_done          <= w_last_pop;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_rcnt == LAST_IDX);

      if (w_start_acc) begin
        r_wcnt <= '0;
        r_rcnt <= '0;
      end else begin
        if (w_wr_acc) begin
          r_wcnt <= r_wcnt + CW'(1);
        end
        if (w_issue) begin
          r_rcnt <= r_rcnt + CW'(1);
        end
      end

      // A word arriving together with start is still dropped, so its flag wins over the clear.
      if (w_start_acc) begin
        r_overflow <= in_valid;
      end else if (in_valid && (r_state != ST_FILL)) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Read data returning from the previous cycle's issue lands in the FIFO.
  adc_ram_frame_ofifo #(
    .WIDTH (DWIDTH + 1)
  ) u_ofifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_inflight),
    .i_push_data ({r_inflight_last, ram_rdat}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_fcnt)
  );

  assign ram_raddr = AWIDTH'(r_rcnt);
  assign out_valid = (w_fcnt != 2'd0);
  assign out_data  = w_head[DWIDTH-1:0];
  assign out_last  = out_valid && w_head[DWIDTH];
  assign busy      = r_busy;
  assign done      = r_done;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_adc_ram_frame_ctrl.sv
// Bench for adc_ram_frame_ctrl: a 16-word instance and a full 8192-word
// instance, each backed by a behavioural adc_ram with one-cycle read latency.
module tb_adc_ram_frame_ctrl;
  import adc_ram_frame_ctrl_pkg::*;

  localparam int unsigned DW    = 160;
  localparam int unsigned AW    = 13;
  localparam int unsigned FW    = 16;
  localparam int unsigned FWB   = 8192;
  localparam int unsigned CHK_W = DW + 1;
  typedef logic [CHK_W-1:0] chk_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, in_valid, out_ready;
  logic [DW-1:0] in_data, ram_wdat, ram_rdat, out_data;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic ram_wen, out_valid, out_last, busy, done, overflow;

  logic b_start, b_in_valid, b_out_ready;
  logic [DW-1:0] b_in_data, b_ram_wdat, b_ram_rdat, b_out_data;
  logic [AW-1:0] b_ram_waddr, b_ram_raddr;
  logic b_ram_wen, b_out_valid, b_out_last, b_busy, b_done, b_overflow;

  adc_ram_frame_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .FRAME_WORDS(FW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdat(ram_wdat),
    .ram_raddr(ram_raddr), .ram_rdat(ram_rdat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .overflow(overflow)
  );

  adc_ram_frame_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .FRAME_WORDS(FWB)) u_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid), .in_data(b_in_data),
    .ram_wen(b_ram_wen), .ram_waddr(b_ram_waddr), .ram_wdat(b_ram_wdat),
    .ram_raddr(b_ram_raddr), .ram_rdat(b_ram_rdat),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last),
    .busy(b_busy), .done(b_done), .overflow(b_overflow)
  );

  // Behavioural adc_ram models: registered read, contents never cleared.
  logic [DW-1:0] mem_s [2**AW];
  logic [DW-1:0] mem_b [2**AW];
  always @(posedge clk) begin
    if (ram_wen) mem_s[ram_waddr] <= ram_wdat;
    ram_rdat <= mem_s[ram_raddr];
    if (b_ram_wen) mem_b[b_ram_waddr] <= b_ram_wdat;
    b_ram_rdat <= mem_b[b_ram_raddr];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input chk_t obs, input chk_t exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: {last, data} pushed at write time, popped on accepted output.
  chk_t sb_q[$];
  chk_t bq[$];
  logic mon_en = 1'b0;
  logic exp_done = 1'b0;
  logic b_exp_done = 1'b0;
  int n_done = 0;
  int b_n_done = 0;
  int b_n_last = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("done", chk_t'(done), chk_t'(exp_done));
      if (done) n_done++;
      exp_done = 1'b0;
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", chk_t'(out_valid), '0);
        end else begin
          chk("out_word", {out_last, out_data}, sb_q[0]);
          if (out_ready) begin
            exp_done = sb_q[0][DW];
            void'(sb_q.pop_front());
          end
        end
      end

      chk("b_done", chk_t'(b_done), chk_t'(b_exp_done));
      if (b_done) b_n_done++;
      b_exp_done = 1'b0;
      if (b_out_valid) begin
        if (bq.size() == 0) begin
          chk("b_sb_underflow", chk_t'(b_out_valid), '0);
        end else begin
          if ({b_out_last, b_out_data} !== bq[0])
            chk("b_out_word", {b_out_last, b_out_data}, bq[0]);
          if (b_out_ready) begin
            n_chk++;
            b_exp_done = bq[0][DW];
            if (b_out_last) b_n_last++;
            void'(bq.pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic fill_frame(input int gap, input bit rnd);
    for (int i = 0; i < int'(FW); i++) begin
      in_valid = 1'b1;
      in_data  = rnd ? {$urandom, $urandom, $urandom, $urandom, $urandom} : DW'(i);
      sb_q.push_back({(i == int'(FW) - 1), in_data});
      #1;
      chk("wen_fill", chk_t'(ram_wen), chk_t'(1));
      chk("waddr", chk_t'(ram_waddr), chk_t'(i));
      tick();
      in_valid = 1'b0;
      if (i != int'(FW) - 1) repeat (gap) tick();
    end
  endtask

  task automatic wait_drain(input string tag, input bit rnd_ready);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 2000) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk(tag, chk_t'(sb_q.size()), '0);
    chk("busy_after", chk_t'(busy), '0);
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    b_start = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", chk_t'(out_valid), '0);
    chk("rst_out_last", chk_t'(out_last), '0);
    chk("rst_busy", chk_t'(busy), '0);
    chk("rst_done", chk_t'(done), '0);
    chk("rst_overflow", chk_t'(overflow), '0);
    chk("rst_raddr", chk_t'(ram_raddr), '0);
    chk("rst_wen", chk_t'(ram_wen), '0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // 1: back-to-back fill, index data, full-rate drain
    start_frame();
    chk("busy_fill", chk_t'(busy), chk_t'(1));
    fill_frame(0, 1'b0);
    chk("busy_drain", chk_t'(busy), chk_t'(1));
    chk("lat_c0", chk_t'(out_valid), '0);
    tick();
    chk("lat_c1", chk_t'(out_valid), '0);
    tick();
    for (int i = 0; i < int'(FW); i++) begin
      chk("stream_valid", chk_t'(out_valid), chk_t'(1));
      tick();
    end
    chk("t1_busy_end", chk_t'(busy), '0);
    chk("t1_valid_end", chk_t'(out_valid), '0);
    tick();
    chk("t1_done_cnt", chk_t'(n_done), chk_t'(1));

    // 2: gapped fill, random backpressure
    start_frame();
    fill_frame(2, 1'b1);
    wait_drain("t2_drain", 1'b1);
    chk("t2_done_cnt", chk_t'(n_done), chk_t'(2));

    // 3: long stall right at drain entry
    out_ready = 1'b0;
    start_frame();
    fill_frame(0, 1'b1);
    repeat (20) tick();
    chk("t3_raddr", chk_t'(ram_raddr), chk_t'(2));
    chk("t3_fcnt", chk_t'(u_dut.w_fcnt), chk_t'(2));
    chk("t3_inflight", chk_t'(u_dut.r_inflight), '0);
    chk("t3_valid", chk_t'(out_valid), chk_t'(1));
    out_ready = 1'b1;
    wait_drain("t3_drain", 1'b0);
    chk("t3_done_cnt", chk_t'(n_done), chk_t'(3));

    // 4: overflow in IDLE and DRAIN, then start together with in_valid
    in_valid = 1'b1; in_data = '1;
    tick();
    in_valid = 1'b0;
    chk("ovf_idle", chk_t'(overflow), chk_t'(1));
    repeat (3) tick();
    chk("ovf_sticky", chk_t'(overflow), chk_t'(1));
    start_frame();
    chk("ovf_clear", chk_t'(overflow), '0);
    fill_frame(0, 1'b1);
    in_valid = 1'b1; in_data = '1;
    #1;
    chk("wen_drain", chk_t'(ram_wen), '0);
    tick();
    in_valid = 1'b0;
    chk("ovf_drain", chk_t'(overflow), chk_t'(1));
    wait_drain("t4_drain", 1'b0);
    chk("ovf_after_frame", chk_t'(overflow), chk_t'(1));
    start = 1'b1; in_valid = 1'b1; in_data = '1;
    #1;
    chk("wen_idle_start", chk_t'(ram_wen), '0);
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("ovf_start_same", chk_t'(overflow), chk_t'(1));
    chk("busy_start_same", chk_t'(busy), chk_t'(1));
    fill_frame(0, 1'b1);
    wait_drain("t4b_drain", 1'b0);
    chk("t4_done_cnt", chk_t'(n_done), chk_t'(5));

    // 5: reset while word 7 of the drain is at the head
    start_frame();
    chk("ovf_clear2", chk_t'(overflow), '0);
    fill_frame(0, 1'b1);
    n = 0;
    while (sb_q.size() > int'(FW) - 7 && n < 200) begin
      tick();
      n++;
    end
    chk("t5_reach_w7", chk_t'(sb_q.size()), chk_t'(FW - 7));
    out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb_q.delete();
    chk("t5_valid", chk_t'(out_valid), '0);
    chk("t5_last", chk_t'(out_last), '0);
    chk("t5_data", chk_t'(out_data), '0);
    chk("t5_busy", chk_t'(busy), '0);
    chk("t5_done", chk_t'(done), '0);
    chk("t5_overflow", chk_t'(overflow), '0);
    chk("t5_raddr", chk_t'(ram_raddr), '0);
    chk("t5_state", chk_t'(u_dut.r_state), chk_t'(ST_IDLE));
    repeat (3) tick();
    chk("t5_no_done", chk_t'(n_done), chk_t'(5));
    out_ready = 1'b1;
    start_frame();
    fill_frame(0, 1'b1);
    wait_drain("t5_drain", 1'b0);
    chk("t5_done_cnt", chk_t'(n_done), chk_t'(6));

    // 6: frame spanning the full address range
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < int'(FWB); i++) begin
      b_in_valid = 1'b1;
      b_in_data  = {$urandom, $urandom, $urandom, $urandom, $urandom};
      bq.push_back({(i == int'(FWB) - 1), b_in_data});
      if (i == 0 || i == int'(FWB) - 1) begin
        #1;
        chk("b_waddr", chk_t'(b_ram_waddr), chk_t'(i));
      end
      tick();
    end
    b_in_valid = 1'b0;
    chk("b_wcnt_park", chk_t'(u_big.r_wcnt), chk_t'(FWB));
    n = 0;
    while (bq.size() != 0 && n < 20000) begin
      tick();
      n++;
    end
    chk("b_drain", chk_t'(bq.size()), '0);
    chk("b_rcnt_park", chk_t'(u_big.r_rcnt), chk_t'(FWB));
    tick();
    tick();
    chk("b_done_cnt", chk_t'(b_n_done), chk_t'(1));
    chk("b_last_cnt", chk_t'(b_n_last), chk_t'(1));
    chk("b_busy_end", chk_t'(b_busy), '0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
